// File: rtl/player_input_ctrl.sv
// Player button front end: synchronizes and debounces the four buttons, then turns them into frame-aligned
// move levels, a buffered one-frame jump pulse and a cooldown-gated attack pulse. Define PLAYER_INPUT_SOCD_EN
// to make left+right resolve as last-pressed-wins instead of cancelling out.

module player_input_deb #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);
  logic             s1, s2, deb, deb_q;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_q <= deb;
      if (s2 == deb)
        cnt <= '0;
      else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb <= ~deb;
        cnt <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  assign level = deb;
  assign rise  = deb & ~deb_q;
endmodule

module player_input_ctrl #(
  parameter int DEB_CYCLES      = 50000,
  parameter int DEB_W           = 16,
  parameter int BUFFER_FRAMES   = 4,
  parameter int ATTACK_COOLDOWN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic SCEN,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  input  logic btn_attack,
  input  logic jump_active,
  output logic move_left,
  output logic move_right,
  output logic jump,
  output logic attack,
  output logic attack_busy
);
  localparam int NUM_LANES = 4;
  localparam int L = 0, R = 1, J = 2, A = 3;
  localparam int AGE_W = (BUFFER_FRAMES > 1) ? $clog2(BUFFER_FRAMES + 1) : 1;
  localparam int CD_W  = (ATTACK_COOLDOWN > 1) ? $clog2(ATTACK_COOLDOWN) : 1;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_FIRE  = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;

  logic [NUM_LANES-1:0] btn_raw, lvl, rise;
  assign btn_raw = {btn_attack, btn_jump, btn_right, btn_left};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_deb
      player_input_deb #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_raw[g]),
        .level (lvl[g]),
        .rise  (rise[g])
      );
    end
  endgenerate

  logic ml_nxt, mr_nxt;
`ifdef PLAYER_INPUT_SOCD_EN
  // Remembers which direction was pressed most recently; only consulted while both are held.
  logic last_right;
  always_ff @(posedge clk) begin
    if (reset)        last_right <= 1'b0;
    else if (rise[R]) last_right <= 1'b1;
    else if (rise[L]) last_right <= 1'b0;
  end
  always_comb begin
    ml_nxt = lvl[L] & ~(lvl[R] & last_right);
    mr_nxt = lvl[R] & ~(lvl[L] & ~last_right);
  end
`else
  always_comb begin
    ml_nxt = lvl[L] & ~lvl[R];
    mr_nxt = lvl[R] & ~lvl[L];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else if (SCEN) begin
      move_left  <= ml_nxt;
      move_right <= mr_nxt;
    end
  end

  // Jump buffer: a press while airborne is held for up to BUFFER_FRAMES frames waiting for landing.
  logic             jump_pending;
  logic [AGE_W-1:0] age;

  always_ff @(posedge clk) begin
    if (reset) begin
      jump         <= 1'b0;
      jump_pending <= 1'b0;
      age          <= '0;
    end else begin
      if (SCEN) begin
        jump <= 1'b0;
        if (jump_pending) begin
          if (!jump_active) begin
            jump         <= 1'b1;
            jump_pending <= 1'b0;
            age          <= '0;
          end else if (int'(age) + 1 >= BUFFER_FRAMES) begin
            jump_pending <= 1'b0;
            age          <= '0;
          end else
            age <= age + 1'b1;
        end
      end
      // A fresh press (re)arms the buffer and restarts its age.
      if (rise[J]) begin
        jump_pending <= 1'b1;
        age          <= '0;
      end
    end
  end

  logic [1:0]      atk_st;
  logic [CD_W-1:0] cd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      atk_st      <= ST_READY;
      cd_cnt      <= '0;
      attack      <= 1'b0;
      attack_busy <= 1'b0;
    end else begin
      case (atk_st)
        ST_READY: begin
          if (SCEN)    attack <= 1'b0;
          if (rise[A]) atk_st <= ST_FIRE;
        end
        ST_FIRE: if (SCEN) begin
          attack      <= 1'b1;
          attack_busy <= 1'b1;
          cd_cnt      <= CD_W'((ATTACK_COOLDOWN > 0) ? ATTACK_COOLDOWN - 1 : 0);
          atk_st      <= ST_COOL;
        end
        ST_COOL: if (SCEN) begin
          attack <= 1'b0;
          if (cd_cnt == '0) begin
            attack_busy <= 1'b0;
            atk_st      <= ST_READY;
          end else
            cd_cnt <= cd_cnt - 1'b1;
        end
        default: atk_st <= ST_READY;
      endcase
    end
  end
endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: frame-level vector table plus hand sequences for debounce timing and reset.
module tb_player_input_ctrl;
  logic clk = 1'b0;
  logic reset, SCEN, btn_left, btn_right, btn_jump, btn_attack, jump_active;
  logic move_left, move_right, jump, attack, attack_busy;
  int checks = 0, errors = 0;

`ifdef PLAYER_INPUT_SOCD_EN
  localparam bit SOCD = 1'b1;
`else
  localparam bit SOCD = 1'b0;
`endif

  player_input_ctrl #(.DEB_CYCLES(4), .DEB_W(16), .BUFFER_FRAMES(2), .ATTACK_COOLDOWN(3)) dut (
    .clk(clk), .reset(reset), .SCEN(SCEN),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_attack(btn_attack),
    .jump_active(jump_active),
    .move_left(move_left), .move_right(move_right), .jump(jump), .attack(attack), .attack_busy(attack_busy)
  );

  always #5 clk = ~clk;

  wire [4:0] outs = {move_left, move_right, jump, attack, attack_busy};

  typedef struct {
    logic l, r, j, a, ja;
    logic [4:0] exp;  // {move_left, move_right, jump, attack, attack_busy}
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic l, r, j, a, ja, input logic [4:0] exp);
    vec_t v;
    v.l = l; v.r = r; v.j = j; v.a = a; v.ja = ja; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick(input bit s);
    SCEN = s;
    @(posedge clk);
    #1;
    SCEN = 1'b0;
  endtask

  task automatic frame();
    repeat (9) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b (ml mr jump attack busy)", nm, got, exp);
    end
  endtask

  task automatic set_btn(input logic l, r, j, a, ja);
    btn_left = l; btn_right = r; btn_jump = j; btn_attack = a; jump_active = ja;
  endtask

  initial begin
    // Each row: inputs held from frame start, outputs checked just after that frame's SCEN.
    add(0,0,0,0,0, 5'b00000);
    add(1,0,0,0,0, 5'b10000);
    add(1,1,0,0,0, SOCD ? 5'b01000 : 5'b00000);  // right pressed after left
    add(0,1,0,0,0, 5'b01000);
    add(1,1,0,0,0, SOCD ? 5'b10000 : 5'b00000);  // left pressed after right
    add(0,0,0,0,0, 5'b00000);
    add(0,0,1,0,0, 5'b00100);                    // jump on ground
    add(0,0,1,0,0, 5'b00000);                    // still held: one frame only
    add(0,0,0,0,0, 5'b00000);
    add(0,0,0,1,0, 5'b00011);                    // attack pulse
    add(0,0,0,0,0, 5'b00001);
    add(0,0,0,1,0, 5'b00001);                    // second press during cooldown
    add(0,0,0,0,0, 5'b00000);                    // busy drops, no pulse from ignored press
    add(0,0,0,1,0, 5'b00011);                    // fresh press accepted
    add(0,0,0,0,0, 5'b00001);
    add(0,0,0,0,0, 5'b00001);
    add(0,0,0,0,0, 5'b00000);
    add(0,0,1,1,0, 5'b00111);                    // jump and attack same frame
    add(0,0,0,0,0, 5'b00001);
    add(0,0,0,0,0, 5'b00001);
    add(0,0,0,0,0, 5'b00000);
    add(0,0,1,0,1, 5'b00000);                    // airborne: buffered
    add(0,0,0,0,0, 5'b00100);                    // landed after 1 frame
    add(0,0,0,0,0, 5'b00000);
    add(0,0,1,0,1, 5'b00000);
    add(0,0,0,0,1, 5'b00000);
    add(0,0,0,0,1, 5'b00000);
    add(0,0,0,0,0, 5'b00000);                    // landed after 3 frames: dropped

    reset = 1'b1; SCEN = 1'b0;
    set_btn(0,0,0,0,0);
    tick(1'b0);
    tick(1'b1);
    chk("reset_state", outs, 5'b00000);
    reset = 1'b0;

    foreach (vecs[i]) begin
      set_btn(vecs[i].l, vecs[i].r, vecs[i].j, vecs[i].a, vecs[i].ja);
      frame();
      chk($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // Two-cycle glitch never reaches the debounced level.
    set_btn(1,0,0,0,0);
    repeat (2) tick(1'b0);
    btn_left = 1'b0;
    repeat (7) tick(1'b0);
    tick(1'b1);
    chk("glitch", outs, 5'b00000);

    // Debounced level lands on the 6th edge after press: SCEN on that edge still sees 0.
    btn_left = 1'b1;
    repeat (5) tick(1'b0);
    tick(1'b1);
    chk("deb_edge6", outs, 5'b00000);
    tick(1'b1);
    chk("deb_edge7", outs, 5'b10000);
    frame();
    chk("left_hold", outs, 5'b10000);
    btn_left = 1'b0;
    frame();
    chk("left_rel", outs, 5'b00000);

    // Reset during cooldown with a buffered jump; reset wins over a coincident SCEN.
    set_btn(0,0,0,1,0);
    frame();
    chk("rst_pre_atk", outs, 5'b00011);
    set_btn(0,0,1,0,1);
    frame();
    chk("rst_pre_cool", outs, 5'b00001);
    set_btn(0,0,0,0,1);
    repeat (4) tick(1'b0);
    reset = 1'b1;
    tick(1'b1);
    chk("rst_prio", outs, 5'b00000);
    reset = 1'b0;
    jump_active = 1'b0;
    frame();
    chk("rst_no_jump", outs, 5'b00000);
    frame();
    chk("rst_idle", outs, 5'b00000);
    btn_attack = 1'b1;
    frame();
    chk("rst_fsm_ready", outs, 5'b00011);
    btn_attack = 1'b0;
    repeat (3) frame();
    chk("rst_cool_done", outs, 5'b00000);

    // Buttons held through reset re-debounce and yield a fresh jump edge.
    set_btn(1,0,1,0,0);
    frame();
    chk("hold_pre", outs, 5'b10100);
    frame();
    chk("hold_pre2", outs, 5'b10000);
    reset = 1'b1;
    tick(1'b0);
    chk("hold_in_rst", outs, 5'b00000);
    reset = 1'b0;
    frame();
    chk("hold_post", outs, 5'b10100);
    set_btn(0,0,0,0,0);
    frame();
    chk("hold_rel", outs, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_input_ctrl.md
PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000: synchronized-input stable cycles required to accept a new debounced level.
REQ-002 SHALL have parameter DEB_W, default 16: debounce counter width.
REQ-003 SHALL have parameter BUFFER_FRAMES, default 4: SCEN frames a pending jump is held while jump_active=1.
REQ-004 SHALL have parameter ATTACK_COOLDOWN, default 8: SCEN frames attack is locked after an attack pulse.
REQ-005 SHALL have port clk  input  1  system clock; sole clock domain.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port SCEN  input  1  one-cycle frame-tick enable.
REQ-008 SHALL have ports btn_left, btn_right, btn_jump, btn_attack  input  1 each  raw asynchronous buttons, active-high.
REQ-009 SHALL have port jump_active  input  1  from player_move; player airborne.
REQ-010 SHALL have ports move_left, move_right  output  1 each  registered direction levels to player_move.
REQ-011 SHALL have port jump  output  1  registered, one-frame jump request to player_move.
REQ-012 SHALL have port attack  output  1  registered, one-frame attack request.
REQ-013 SHALL have port attack_busy  output  1  high during attack cooldown.

Function
REQ-014 SHALL pass each btn_* through a 2-flop synchronizer before any other logic.
REQ-015 SHALL keep one DEB_W-bit counter per button: cleared when the synchronized level equals the debounced level, otherwise incremented each clk; when it reaches DEB_CYCLES-1, the debounced level toggles and the counter clears.
REQ-016 SHALL detect debounced rising edges of jump and attack on clk, independent of SCEN.
REQ-017 SHALL update all outputs only on clk cycles with SCEN=1 and hold them otherwise.
REQ-018 SHALL drive move_left/move_right from debounced left/right at each SCEN, resolved per REQ-030/031 when both are held.
REQ-019 SHALL set jump_pending on a debounced jump rising edge; an edge arriving while already pending restarts the buffer age.
REQ-020 SHALL, at SCEN with jump_pending=1 and jump_active=0: jump<=1, jump_pending<=0, age<=0.
REQ-021 SHALL, at SCEN with jump_pending=1 and jump_active=1: jump<=0 and age+1; when age reaches BUFFER_FRAMES, clear jump_pending (request dropped).
REQ-022 SHALL deassert jump at every SCEN not covered by REQ-020, so jump lasts exactly one frame.
REQ-023 SHALL run attack FSM states READY, FIRE, COOLDOWN: READY->FIRE on debounced attack edge (latched until next SCEN); FIRE at SCEN: attack<=1, attack_busy<=1, cooldown count<=ATTACK_COOLDOWN-1, ->COOLDOWN; COOLDOWN at each SCEN: attack<=0, decrement, ->READY with attack_busy<=0 after count 0.
REQ-024 SHALL ignore attack edges in COOLDOWN (not queued).
REQ-025 SHALL accept ATTACK_COOLDOWN=0 as: attack pulse one frame, return to READY at next SCEN.
REQ-026 SHALL allow jump and attack pulses in the same frame.

Reset
REQ-027 SHALL, on reset=1 at clk edge, clear synchronizers, debounced levels, counters, jump_pending, age, attack FSM (READY) and all outputs to 0.
REQ-028 SHALL let reset take priority over SCEN in the same cycle.
REQ-029 SHALL, on reset mid-jump-buffer or mid-cooldown, discard pending state; buttons held through reset re-debounce from 0 and may create a new rising edge.

Configuration
REQ-030 SHALL, with macro PLAYER_INPUT_SOCD_EN defined, resolve left+right held as last-pressed-wins: the direction whose debounced rising edge came later is asserted, the other 0; on release of one, the remaining one asserts.
REQ-031 SHALL, without PLAYER_INPUT_SOCD_EN, drive move_left=move_right=0 whenever both debounced inputs are 1.

Verification (DEB_CYCLES=4, BUFFER_FRAMES=2, ATTACK_COOLDOWN=3, SCEN every 10 clk)
REQ-032 SHALL test btn_left glitch high 2 clk -> move_left stays 0; held 20 clk -> move_left=1 at first SCEN after 2 sync + 4 debounce clk.
REQ-033 SHALL test jump press with jump_active=0 -> jump=1 for exactly one frame, then 0 despite button still held.
REQ-034 SHALL test jump press while jump_active=1, jump_active falls after 1 frame -> jump=1 next SCEN; falls after 3 frames -> jump never asserts.
REQ-035 SHALL test attack press then second press 1 frame later -> one attack pulse, attack_busy=1 for 3 frames, second press ignored; press after busy=0 -> new pulse.
REQ-036 SHALL test left held, then right pressed -> with PLAYER_INPUT_SOCD_EN: move_right=1, move_left=0; without: both 0.
REQ-037 SHALL test reset asserted during COOLDOWN with jump pending -> all outputs 0 next clk, FSM READY, no jump pulse after release.
